// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: FIFO of floor calls dispatched one at a time to a lift controller,
// with duplicate merging, range/overflow rejection and a dwell period after each arrival.
module lift_call_scheduler #(
    parameter int DEPTH        = 8,
    parameter int MAX_FLOOR    = 63,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     call_valid,
    input  logic [6:0]               call_floor,
    input  logic [6:0]               cur_floor,
    input  logic                     stop,
    output logic [6:0]               req_floor,
    output logic                     busy,
    output logic                     arrive,
    output logic                     call_drop,
    output logic [$clog2(DEPTH):0]   pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DWELL_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DISPATCH, TRAVEL, DWELL} state_t;
    state_t          state;
    logic [6:0]      mem [DEPTH];
    logic [DEPTH-1:0] vld, vld_n;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   dwell_cnt;
    logic            in_range, dup, full, push, pop, drop;
    assign in_range = call_floor <= 7'(MAX_FLOOR);
    assign full     = pending == (AW+1)'(DEPTH);
    assign pop      = state == DISPATCH;
    assign push     = call_valid && in_range && !dup && !full;
    assign drop     = call_valid && (!in_range || (!dup && full));
    // only occupied slots take part in the duplicate check, so stale storage never merges
    always_comb begin
        dup = (state == TRAVEL || state == DWELL) && req_floor == call_floor;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i] && mem[i] == call_floor) dup = 1'b1;
    end
    always_comb begin
        vld_n = vld;
        if (pop) vld_n[rd_ptr] = 1'b0;
        if (push) vld_n[wr_ptr] = 1'b1;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            req_floor <= '0;
            busy      <= 1'b0;
            arrive    <= 1'b0;
            call_drop <= 1'b0;
            pending   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            dwell_cnt <= '0;
            vld       <= '0;
        end else begin
            call_drop <= drop;
            arrive    <= 1'b0;
            vld       <= vld_n;
            pending   <= pending + (AW+1)'(push) - (AW+1)'(pop);
            if (push) begin
                mem[wr_ptr] <= call_floor;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                req_floor <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
            case (state)
                IDLE: if (pending != 0) begin
                    state <= DISPATCH;
                    busy  <= 1'b1;
                end
                DISPATCH: state <= TRAVEL;
                TRAVEL: if (stop && cur_floor == req_floor) begin
                    state     <= DWELL;
                    arrive    <= 1'b1;
                    dwell_cnt <= '0;
                end
                DWELL: if (dwell_cnt == CW'(DWELL_CYCLES - 1)) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb_lift_call_scheduler: scoreboard bench with a simple lift model that walks one floor per cycle.
module tb_lift_call_scheduler;
    logic       clk = 0, reset = 0, call_valid = 0, stop = 0;
    logic [6:0] call_floor = 0, cur_floor = 0;
    logic [6:0] req_floor;
    logic       busy, arrive, call_drop;
    logic [3:0] pending;
    int total = 0, bad = 0, arrivals = 0, arr12 = 0, pushes = 0;
    int q[$];
    bit hold = 0;

    lift_call_scheduler dut (
        .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
        .cur_floor(cur_floor), .stop(stop), .req_floor(req_floor), .busy(busy),
        .arrive(arrive), .call_drop(call_drop), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int f, input bit acc);
        call_floor = 7'(f);
        call_valid = 1;
        if (acc) begin
            q.push_back(f);
            pushes++;
        end
        @(negedge clk);
        call_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((busy || pending != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(n < 5000), 1);
    endtask

    // lift model: one floor per cycle, stop once parked at the target, held still when hold=1
    initial forever begin
        @(negedge clk);
        if (hold) stop = 0;
        else if (cur_floor < req_floor) begin cur_floor = cur_floor + 1; stop = 0; end
        else if (cur_floor > req_floor) begin cur_floor = cur_floor - 1; stop = 0; end
        else stop = 1;
    end

    initial forever begin
        @(negedge clk);
        if (arrive === 1'b1) begin
            arrivals++;
            if (req_floor == 12) arr12++;
            if (q.size() == 0) chk("arrive_unexp", 1, 0);
            else chk("order", int'(req_floor), q.pop_front());
        end
    end

    initial begin
        int n, a0;
        call_valid = 1;
        call_floor = 5;
        cyc(3);
        chk("rst_req", int'(req_floor), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_arrive", int'(arrive), 0);
        chk("rst_drop", int'(call_drop), 0);
        chk("rst_pending", int'(pending), 0);
        call_valid = 0;
        reset = 1;
        cyc(1);
        chk("rst_ignore", int'(pending), 0);

        send(25, 1);
        chk("s_pend", int'(pending), 1);
        chk("s_busy0", int'(busy), 0);
        cyc(1);
        chk("s_busy1", int'(busy), 1);
        chk("s_req_old", int'(req_floor), 0);
        cyc(1);
        chk("s_req25", int'(req_floor), 25);
        n = 0;
        while (!arrive && n < 200) begin cyc(1); n++; end
        chk("s_arrive", int'(arrive), 1);
        n = 0;
        while (busy && n < 20) begin cyc(1); n++; end
        chk("s_dwell", n, 4);
        chk("s_park", int'(req_floor), 25);

        send(3, 1);
        send(37, 1);
        send(10, 1);
        chk("f_pend", int'(pending), 2);
        wait_done("f_tmo");
        chk("f_pend0", int'(pending), 0);

        send(50, 1);
        cyc(3);
        send(12, 1);
        chk("d_drop1", int'(call_drop), 0);
        chk("d_pend1", int'(pending), 1);
        send(12, 0);
        chk("d_drop2", int'(call_drop), 0);
        chk("d_pend2", int'(pending), 1);
        n = 0;
        while (req_floor != 12 && n < 500) begin cyc(1); n++; end
        chk("d_tmo", int'(n < 500), 1);
        send(12, 0);
        chk("d_drop3", int'(call_drop), 0);
        chk("d_pend3", int'(pending), 0);
        wait_done("d_done");
        chk("d_arr12", arr12, 1);

        hold = 1;
        send(60, 1);
        cyc(3);
        for (int i = 1; i <= 8; i++) send(i, 1);
        chk("o_full", int'(pending), 8);
        send(9, 0);
        chk("o_drop", int'(call_drop), 1);
        chk("o_full2", int'(pending), 8);
        cyc(1);
        chk("o_pulse", int'(call_drop), 0);
        send(64, 0);
        chk("o_rng", int'(call_drop), 1);
        chk("o_full3", int'(pending), 8);
        hold = 0;
        wait_done("o_done");

        send(64, 0);
        chk("r_drop", int'(call_drop), 1);
        chk("r_pend", int'(pending), 0);
        for (int i = 0; i < 20; i++) begin
            n = 0;
            while (pending >= 8 && n < 3000) begin cyc(1); n++; end
            send((i * 7 + 5) % 60, 1);
            chk("w_drop", int'(call_drop), 0);
        end
        wait_done("w_done");
        chk("w_empty", q.size(), 0);
        chk("w_count", arrivals, pushes);

        hold = 1;
        send(40, 1);
        cyc(3);
        send(41, 1);
        send(42, 1);
        send(43, 1);
        chk("m_pend3", int'(pending), 3);
        reset = 0;
        cyc(1);
        reset = 1;
        chk("m_req", int'(req_floor), 0);
        chk("m_pend", int'(pending), 0);
        chk("m_busy", int'(busy), 0);
        chk("m_arrive", int'(arrive), 0);
        q.delete();
        a0 = arrivals;
        hold = 0;
        cyc(80);
        chk("m_noarr", arrivals, a0);

        chk("h_stop", int'(stop), 1);
        chk("h_cur", int'(cur_floor), 0);
        send(0, 1);
        cyc(2);
        chk("h_arr0", int'(arrive), 0);
        cyc(1);
        chk("h_arr1", int'(arrive), 1);
        wait_done("h_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
